// File: rtl/two_bit_counter.sv
// two_bit_counter: 2-bit synchronous up-counter built from two toggle stages
module two_bit_counter #(
    parameter logic [1:0] RESET_VALUE = 2'b00
) (
    output logic q2,
    output logic q1,
    input  logic clk,
    input  logic d1,
    input  logic rst
);
    // LSB toggles on every enabled edge; MSB toggles when the pre-edge LSB is set
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            q2 <= RESET_VALUE[1];
            q1 <= RESET_VALUE[0];
        end else if (d1) begin
            q2 <= q2 ^ q1;
            q1 <= ~q1;
        end
endmodule

// File: tb/tb_two_bit_counter.sv
// tb_two_bit_counter: table-driven scoreboard bench for two_bit_counter
module tb_two_bit_counter;
    typedef struct {
        logic       r;
        logic       d;
        logic [1:0] ea;
        logic [1:0] eb;
    } vec_t;
    typedef struct {
        logic [1:0] ea;
        logic [1:0] eb;
        int         idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic d1;
    logic qa2, qa1, qb2, qb1;
    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    vec_t tv[25];
    logic [1:0] pa = 2'b00;
    logic [1:0] pb = 2'b10;

    two_bit_counter #(.RESET_VALUE(2'b00)) dut_a (.q2(qa2), .q1(qa1), .clk(clk), .d1(d1), .rst(rst));
    two_bit_counter #(.RESET_VALUE(2'b10)) dut_b (.q2(qb2), .q1(qb1), .clk(clk), .d1(d1), .rst(rst));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b want %b", nm, idx, act, exp);
        end
    endtask

    initial begin
        tv[0]  = '{1, 1, 2'b00, 2'b10};
        tv[1]  = '{1, 1, 2'b00, 2'b10};
        tv[2]  = '{0, 1, 2'b01, 2'b11};
        tv[3]  = '{0, 1, 2'b10, 2'b00};
        tv[4]  = '{0, 1, 2'b11, 2'b01};
        tv[5]  = '{0, 1, 2'b00, 2'b10};
        tv[6]  = '{0, 1, 2'b01, 2'b11};
        tv[7]  = '{0, 1, 2'b10, 2'b00};
        tv[8]  = '{0, 1, 2'b11, 2'b01};
        tv[9]  = '{0, 1, 2'b00, 2'b10};
        tv[10] = '{0, 1, 2'b01, 2'b11};
        tv[11] = '{0, 1, 2'b10, 2'b00};
        tv[12] = '{0, 0, 2'b10, 2'b00};
        tv[13] = '{0, 0, 2'b10, 2'b00};
        tv[14] = '{0, 0, 2'b10, 2'b00};
        tv[15] = '{0, 1, 2'b11, 2'b01};
        tv[16] = '{0, 1, 2'b00, 2'b10};
        tv[17] = '{0, 1, 2'b01, 2'b11};
        tv[18] = '{0, 1, 2'b10, 2'b00};
        tv[19] = '{0, 1, 2'b11, 2'b01};
        tv[20] = '{1, 1, 2'b00, 2'b10};
        tv[21] = '{1, 0, 2'b00, 2'b10};
        tv[22] = '{0, 1, 2'b01, 2'b11};
        tv[23] = '{0, 1, 2'b10, 2'b00};
        tv[24] = '{0, 1, 2'b11, 2'b01};
        rst = 1'b1;
        d1  = 1'b1;
        for (int i = 0; i < 25; i++) begin
            exp_t e;
            if (i > 0) @(negedge clk);
            rst = tv[i].r;
            d1  = tv[i].d;
            sb.push_back('{tv[i].ea, tv[i].eb, i});
            if (i > 0) begin
                #1;
                chk("pre_edge_a", i, {qa2, qa1}, tv[i].r ? 2'b00 : pa);
                chk("pre_edge_b", i, {qb2, qb1}, tv[i].r ? 2'b10 : pb);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("count_a", e.idx, {qa2, qa1}, e.ea);
            chk("count_b", e.idx, {qb2, qb1}, e.eb);
            pa = e.ea;
            pb = e.eb;
        end
        @(negedge clk);
        d1 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wrap_a", k, {qa2, qa1}, 2'b00);
            chk("wrap_b", k, {qb2, qb1}, 2'b10);
            d1 = k[0];
        end
        @(negedge clk);
        d1 = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_after_glitch_a", 0, {qa2, qa1}, 2'b00);
        chk("hold_after_glitch_b", 0, {qb2, qb1}, 2'b10);
        chk("sb_empty", 0, 2'(sb.size()), 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
